// File: rtl/packet_bus_router_if.sv
// Bus bundle shared by the packet router and its endpoints.
// Ports (per endpoint p, data slice [p*DATA_W +: DATA_W]):
//   send_valid/send_data/send_last : endpoint -> router beat stream
//   send_ready                     : router -> endpoint, beat accepted on valid&&ready
//   recv_valid/recv_data/recv_last : router -> endpoint beat stream
//   recv_ready                     : endpoint -> router, endpoint can take a beat
// master = endpoint side, slave = router side.
interface packet_bus_router_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8
);
   logic [NUM_PORTS-1:0]        send_valid;
   logic [NUM_PORTS*DATA_W-1:0] send_data;
   logic [NUM_PORTS-1:0]        send_last;
   logic [NUM_PORTS-1:0]        send_ready;
   logic [NUM_PORTS-1:0]        recv_valid;
   logic [NUM_PORTS*DATA_W-1:0] recv_data;
   logic [NUM_PORTS-1:0]        recv_last;
   logic [NUM_PORTS-1:0]        recv_ready;

   modport master (
      output send_valid, send_data, send_last, recv_ready,
      input  send_ready, recv_valid, recv_data, recv_last
   );

   modport slave (
      input  send_valid, send_data, send_last, recv_ready,
      output send_ready, recv_valid, recv_data, recv_last
   );
endinterface

// File: rtl/packet_bus_router.sv
// Central N-port packet router. Arbitrates senders (CTRL_ID strict priority,
// then round-robin after rr_ptr), decodes the destination from the header
// beat and streams the packet to that receive port until last.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : slave modport of packet_bus_router_if (send/recv streams)
//   busy        : a packet is open
//   grant_id    : granted endpoint, 0 when idle
//   hdr_err     : 1-cycle pulse on a header transfer with bad dest or src
//   timeout_err : 1-cycle pulse when an open packet is aborted for stalling
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no packet open, arbitrate among requesters
// S_HEADER  | granted, header beat routed by its own dest field
// S_STREAM  | body beats routed to the latched dest
// S_DISCARD | bad dest, beats accepted and dropped until last
module packet_bus_router #(
   parameter int DATA_W    = 8,
   parameter int NUM_PORTS = 4,
   parameter int ID_W      = 2,
   parameter int CTRL_ID   = 3,
   parameter int SRC_LSB   = 2,
   parameter int DEST_LSB  = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   packet_bus_router_if.slave  bus,
   output logic                busy,
   output logic [ID_W-1:0]     grant_id,
   output logic                hdr_err,
   output logic                timeout_err
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // Fires on the idle cycle that would bring the count up to TIMEOUT.
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [ID_W-1:0]  RR_RST   = ID_W'(NUM_PORTS - 1);
   localparam logic [ID_W-1:0]  CTRL     = ID_W'(CTRL_ID);
   localparam logic [ID_W:0]    PORTS_EXT = (ID_W + 1)'(NUM_PORTS);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM, S_DISCARD} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   dest_q, dest_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [ID_W-1:0]   pick;
   logic              any_req;
   logic [DATA_W-1:0] g_data;
   logic              g_valid, g_last;
   logic [ID_W-1:0]   hd_dest, hd_src;
   logic              dest_ok;
   logic              fwd_en, sready_g, xfer, to_fire, open_pkt;
   logic [ID_W-1:0]   fwd_dest;

   logic [NUM_PORTS-1:0]        send_ready_o, recv_valid_o, recv_last_o;
   logic [NUM_PORTS*DATA_W-1:0] recv_data_o;

   assign g_data   = bus.send_data[int'(grant_q)*DATA_W +: DATA_W];
   assign g_valid  = bus.send_valid[grant_q];
   assign g_last   = bus.send_last[grant_q];
   assign hd_dest  = g_data[DEST_LSB +: ID_W];
   assign hd_src   = g_data[SRC_LSB +: ID_W];
   assign dest_ok  = {1'b0, hd_dest} < PORTS_EXT;
   assign any_req  = |bus.send_valid;
   assign open_pkt = (state_q != S_IDLE);
   assign xfer     = g_valid & sready_g;
   assign to_fire  = (TIMEOUT > 0) && open_pkt && !xfer && (cnt_q == CNT_FIRE);

   // Descending scan so the nearest port after rr_ptr is the last to win.
   always_comb begin
      pick = CTRL;
      if (!bus.send_valid[CTRL_ID]) begin
         pick = rr_q;
         for (int i = NUM_PORTS; i >= 1; i--) begin
            if (bus.send_valid[(int'(rr_q) + i) % NUM_PORTS])
               pick = ID_W'((int'(rr_q) + i) % NUM_PORTS);
         end
      end
   end

   // Routing decision for the granted sender; kept apart from the outputs so
   // xfer/to_fire do not feed back into the block that consumes them.
   always_comb begin
      fwd_en   = 1'b0;
      fwd_dest = dest_q;
      sready_g = 1'b0;
      case (state_q)
         S_HEADER: begin
            if (dest_ok) begin
               fwd_en   = 1'b1;
               fwd_dest = hd_dest;
               sready_g = bus.recv_ready[hd_dest];
            end else begin
               sready_g = 1'b1;
            end
         end
         S_STREAM: begin
            fwd_en   = 1'b1;
            sready_g = bus.recv_ready[dest_q];
         end
         S_DISCARD: sready_g = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         dest_q  <= '0;
         rr_q    <= RR_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         dest_q  <= dest_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      dest_d  = dest_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE) begin
         cnt_d = '0;
         if (any_req) begin
            state_d = S_HEADER;
            grant_d = pick;
         end
      end else if (to_fire) begin
         // Remaining beats of the stalled packet re-arbitrate as a new packet.
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (xfer) begin
         cnt_d = '0;
         if (g_last) begin
            state_d = S_IDLE;
            rr_d    = grant_q;
         end else if (state_q == S_HEADER) begin
            if (dest_ok) begin
               state_d = S_STREAM;
               dest_d  = hd_dest;
            end else begin
               state_d = S_DISCARD;
            end
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      send_ready_o = '0;
      recv_valid_o = '0;
      recv_data_o  = '0;
      recv_last_o  = '0;
      busy         = open_pkt;
      grant_id     = open_pkt ? grant_q : '0;
      hdr_err      = 1'b0;
      timeout_err  = to_fire;
      if (open_pkt)
         send_ready_o[grant_q] = sready_g;
      if (fwd_en) begin
         recv_valid_o[fwd_dest]                         = g_valid;
         recv_data_o[int'(fwd_dest)*DATA_W +: DATA_W]   = g_data;
         recv_last_o[fwd_dest]                          = g_last;
      end
      if (state_q == S_HEADER && xfer && (!dest_ok || hd_src != grant_q))
         hdr_err = 1'b1;
   end

   assign bus.send_ready = send_ready_o;
   assign bus.recv_valid = recv_valid_o;
   assign bus.recv_data  = recv_data_o;
   assign bus.recv_last  = recv_last_o;
endmodule

// File: tb/tb_packet_bus_router.sv
// Directed bench for packet_bus_router: a default 4-port instance and a
// 3-port instance (CTRL_ID=2, TIMEOUT=4) for bad-dest and stall behaviour.
module tb_packet_bus_router;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   packet_bus_router_if #(.NUM_PORTS(4), .DATA_W(8)) bus4 ();
   packet_bus_router_if #(.NUM_PORTS(3), .DATA_W(8)) bus3 ();

   logic       busy4, hdr_err4, to_err4;
   logic [1:0] grant4;
   logic       busy3, hdr_err3, to_err3;
   logic [1:0] grant3;

   packet_bus_router u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4),
      .busy(busy4), .grant_id(grant4), .hdr_err(hdr_err4), .timeout_err(to_err4)
   );

   packet_bus_router #(.NUM_PORTS(3), .CTRL_ID(2), .TIMEOUT(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3),
      .busy(busy3), .grant_id(grant3), .hdr_err(hdr_err3), .timeout_err(to_err3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      bus4.send_valid = '0;
      bus4.send_data  = '0;
      bus4.send_last  = '0;
      bus4.recv_ready = '1;
      bus3.send_valid = '0;
      bus3.send_data  = '0;
      bus3.send_last  = '0;
      bus3.recv_ready = '1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         exp_rr [4];
   logic [7:0] beats [4];
   logic [7:0] rx [$];
   int         k, stalls;

   initial begin
      exp_rr = '{0, 1, 2, 0};
      beats  = '{8'h10, 8'h11, 8'h22, 8'h33};

      // Reset with arbitrary inputs held
      rst_n = 1'b0;
      bus4.send_valid = 4'($urandom());
      bus4.send_data  = $urandom();
      bus4.send_last  = 4'($urandom());
      bus4.recv_ready = 4'($urandom());
      bus3.send_valid = 3'b111;
      bus3.send_data  = 24'($urandom());
      bus3.send_last  = 3'b101;
      bus3.recv_ready = 3'b010;
      repeat (3) @(posedge clk);
      mid;
      check_eq("rst_send_ready", 32'(bus4.send_ready), 32'h0);
      check_eq("rst_recv_valid", 32'(bus4.recv_valid), 32'h0);
      check_eq("rst_recv_data", bus4.recv_data, 32'h0);
      check_eq("rst_recv_last", 32'(bus4.recv_last), 32'h0);
      check_eq("rst_status", 32'({busy4, grant4, hdr_err4, to_err4}), 32'h0);
      check_eq("rst3_outputs", 32'({bus3.send_ready, bus3.recv_valid, bus3.recv_last, bus3.recv_data, busy3, grant3}), 32'h0);
      cyc;
      idle_inputs;
      rst_n = 1'b1;

      // Single 2-beat packet port1 -> port2
      cyc;
      bus4.send_valid = 4'b0010;
      bus4.send_data[15:8] = 8'h24;
      mid;
      check_eq("t1_idle_busy", 32'(busy4), 32'h0);
      cyc; mid;
      check_eq("t1_grant", 32'(grant4), 32'h1);
      check_eq("t1_hdr_valid", 32'(bus4.recv_valid), 32'h4);
      check_eq("t1_hdr_data", bus4.recv_data, 32'h0024_0000);
      check_eq("t1_hdr_ready", 32'(bus4.send_ready), 32'h2);
      check_eq("t1_hdr_err", 32'(hdr_err4), 32'h0);
      cyc;
      bus4.send_data[15:8] = 8'hAA;
      bus4.send_last[1] = 1'b1;
      mid;
      check_eq("t1_body_data", bus4.recv_data, 32'h00AA_0000);
      check_eq("t1_body_last", 32'(bus4.recv_last), 32'h4);
      cyc;
      idle_inputs;
      mid;
      check_eq("t1_back_idle", 32'({busy4, grant4, bus4.recv_valid}), 32'h0);

      // Round robin over ports 0..2, then CTRL jumps the queue
      cyc; rst_n = 1'b0;
      cyc; rst_n = 1'b1;
      cyc;
      bus4.send_valid = 4'b0111;
      bus4.send_data  = 32'h0008_2410;
      bus4.send_last  = 4'b0111;
      mid;
      check_eq("t2_start_idle", 32'(busy4), 32'h0);
      for (int n = 0; n < 4; n++) begin
         cyc; mid;
         check_eq("t2_rr_grant", 32'(grant4), 32'(exp_rr[n]));
         if (n == 3) begin
            bus4.send_valid[3] = 1'b1;
            bus4.send_data[31:24] = 8'h0C;
            bus4.send_last[3] = 1'b1;
         end
         cyc; mid;
         check_eq("t2_gap_idle", 32'(busy4), 32'h0);
      end
      cyc; mid;
      check_eq("t2_ctrl_grant", 32'(grant4), 32'h3);
      check_eq("t2_ctrl_valid", 32'(bus4.recv_valid), 32'h1);
      check_eq("t2_ctrl_data", bus4.recv_data, 32'h0000_000C);
      cyc;
      bus4.send_valid[3] = 1'b0;
      mid;
      check_eq("t2_post_ctrl_gap", 32'(busy4), 32'h0);
      cyc; mid;
      check_eq("t2_after_ctrl_grant", 32'(grant4), 32'h0);
      cyc;
      idle_inputs;
      mid;
      check_eq("t2_drain", 32'(busy4), 32'h0);

      // Backpressure: 4-beat packet port0 -> port1 with 5 stalled cycles
      k = 0;
      stalls = 0;
      rx.delete();
      cyc;
      for (int c = 0; c < 20; c++) begin
         bus4.send_valid[0] = (k < 4);
         bus4.send_data[7:0] = (k < 4) ? beats[k] : 8'h00;
         bus4.send_last[0] = (k == 3);
         bus4.recv_ready[1] = !(c >= 3 && c <= 7);
         mid;
         if (busy4 && !bus4.send_ready[0]) stalls++;
         if (bus4.recv_valid[1] && bus4.recv_ready[1]) rx.push_back(bus4.recv_data[15:8]);
         if (bus4.send_valid[0] && bus4.send_ready[0]) k++;
         cyc;
      end
      idle_inputs;
      check_eq("t3_stall_cycles", 32'(stalls), 32'd5);
      check_eq("t3_rx_count", 32'(rx.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check_eq("t3_rx_beat", (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(beats[i]));

      // 3-port instance: bad destination discarded
      bus3.send_valid = 3'b001;
      bus3.send_data[7:0] = 8'h30;
      mid;
      check_eq("t4_idle", 32'(busy3), 32'h0);
      cyc; mid;
      check_eq("t4_bad_dest_err", 32'(hdr_err3), 32'h1);
      check_eq("t4_hdr_ready", 32'(bus3.send_ready), 32'h1);
      check_eq("t4_hdr_no_fwd", 32'(bus3.recv_valid), 32'h0);
      cyc;
      bus3.send_data[7:0] = 8'h55;
      mid;
      check_eq("t4_body_err", 32'(hdr_err3), 32'h0);
      check_eq("t4_body_drop", 32'({bus3.recv_valid, bus3.send_ready, busy3}), 32'b000_001_1);
      cyc;
      bus3.send_data[7:0] = 8'h66;
      bus3.send_last[0] = 1'b1;
      mid;
      check_eq("t4_last_drop", 32'({bus3.recv_valid, bus3.send_ready}), 32'b000_001);
      cyc;
      idle_inputs;
      mid;
      check_eq("t4_back_idle", 32'(busy3), 32'h0);

      // Source field mismatch still forwards
      cyc;
      bus3.send_valid = 3'b010;
      bus3.send_data[15:8] = 8'h20;
      bus3.send_last = 3'b010;
      mid;
      cyc; mid;
      check_eq("t4_src_grant", 32'(grant3), 32'h1);
      check_eq("t4_src_err", 32'(hdr_err3), 32'h1);
      check_eq("t4_src_valid", 32'(bus3.recv_valid), 32'h4);
      check_eq("t4_src_data", 32'(bus3.recv_data), 32'h20_0000);
      check_eq("t4_src_last", 32'(bus3.recv_last), 32'h4);
      cyc;
      idle_inputs;
      mid;
      check_eq("t4_src_idle", 32'(busy3), 32'h0);

      // Stall timeout after header
      cyc;
      bus3.send_valid = 3'b001;
      bus3.send_data[7:0] = 8'h10;
      mid;
      cyc; mid;
      check_eq("t5_header_busy", 32'(busy3), 32'h1);
      cyc;
      bus3.send_valid = '0;
      mid;
      check_eq("t5_idle1_no_to", 32'(to_err3), 32'h0);
      cyc; mid;
      cyc; mid;
      check_eq("t5_idle3_no_to", 32'({to_err3, busy3}), 32'b01);
      cyc; mid;
      check_eq("t5_timeout_pulse", 32'({to_err3, busy3}), 32'b11);
      cyc; mid;
      check_eq("t5_after_timeout", 32'({to_err3, busy3}), 32'b00);

      // Async reset mid-stream, then a fresh packet
      cyc;
      bus4.send_valid = 4'b0100;
      bus4.send_data[23:16] = 8'h38;
      mid;
      cyc; mid;
      check_eq("t6_grant", 32'(grant4), 32'h2);
      check_eq("t6_hdr_data", bus4.recv_data, 32'h3800_0000);
      cyc;
      bus4.send_data[23:16] = 8'h77;
      mid;
      check_eq("t6_stream_valid", 32'(bus4.recv_valid), 32'h8);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_recv", 32'({bus4.recv_valid, bus4.recv_last}), 32'h0);
      check_eq("t6_rst_data", bus4.recv_data, 32'h0);
      check_eq("t6_rst_status", 32'({bus4.send_ready, busy4, grant4}), 32'h0);
      cyc;
      idle_inputs;
      cyc;
      rst_n = 1'b1;
      cyc;
      bus4.send_valid = 4'b0010;
      bus4.send_data[15:8] = 8'h04;
      bus4.send_last = 4'b0010;
      mid;
      cyc; mid;
      check_eq("t6_fresh_grant", 32'(grant4), 32'h1);
      check_eq("t6_fresh_valid", 32'(bus4.recv_valid), 32'h1);
      check_eq("t6_fresh_data", bus4.recv_data, 32'h0000_0004);
      check_eq("t6_fresh_last", 32'(bus4.recv_last), 32'h1);
      cyc;
      idle_inputs;
      mid;
      check_eq("t6_fresh_idle", 32'(busy4), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/packet_bus_router.md
Name: packet_bus_router

Overview:
- Parametrised successor to the shared 8-bit tri-state data bus. Replaces distributed tri-state ownership with a central, fully synchronous N-port packet router.
- Each endpoint presents a valid/ready/last send stream. The router arbitrates between endpoints, decodes the destination from the header beat, and streams the packet to the destination's receive port until last.
- The control endpoint (CTRL_ID) keeps strict priority. Adds round-robin fairness, backpressure, bad-destination discard and a stall timeout.

Parameters:
- DATA_W, 8, beat width in bits.
- NUM_PORTS, 4, number of endpoints; must be 2..2**ID_W.
- ID_W, 2, width of the source/dest fields in the header.
- CTRL_ID, 3, endpoint with strict priority.
- SRC_LSB, 2, LSB of the source field in the header beat.
- DEST_LSB, 4, LSB of the dest field in the header beat.
- TIMEOUT, 255, max consecutive no-transfer cycles while a packet is open; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- send_valid  in  NUM_PORTS  per-endpoint beat valid
- send_data  in  NUM_PORTS*DATA_W  per-endpoint beat; port p occupies [p*DATA_W +: DATA_W]
- send_last  in  NUM_PORTS  marks the final beat of a packet
- send_ready  out  NUM_PORTS  beat accepted when valid&&ready
- recv_valid  out  NUM_PORTS  beat valid toward endpoint
- recv_data  out  NUM_PORTS*DATA_W  beat toward endpoint
- recv_last  out  NUM_PORTS  final beat toward endpoint
- recv_ready  in  NUM_PORTS  endpoint can accept a beat
- busy  out  1  a packet is open
- grant_id  out  ID_W  currently granted endpoint; 0 when idle
- hdr_err  out  1  1-cycle pulse on a bad header
- timeout_err  out  1  1-cycle pulse on a stall abort

Behaviour:
- Reset (async, rst_n=0): state IDLE; rr_ptr=NUM_PORTS-1; counter=0; every output 0. Reset mid-packet abandons the packet and leaves no residual grant.
- States: IDLE, HEADER, STREAM, DISCARD.
- IDLE: send_ready=0 on all ports.
  - If send_valid[CTRL_ID]: grant CTRL_ID.
  - Else: grant the first asserted port searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Grant registers on the clock edge; next state is HEADER.
  - Arbitration latency: 1 cycle from request to grant.
- HEADER (granted port g):
  - dest = send_data[g][DEST_LSB +: ID_W], decoded combinationally.
  - dest < NUM_PORTS: recv_valid[dest]=send_valid[g], recv_data/recv_last pass through, send_ready[g]=recv_ready[dest].
  - On transfer, dest is latched. Next state is STREAM, or IDLE if send_last.
  - dest >= NUM_PORTS: send_ready[g]=1 and nothing is forwarded. hdr_err pulses on the transfer. Next state is DISCARD, or IDLE if send_last.
  - Source field != g: hdr_err pulses, but the packet is still forwarded normally.
- STREAM: zero-latency combinational pass-through from g to the latched dest; send_ready[g]=recv_ready[dest]. A transfer with send_last returns to IDLE.
- DISCARD: send_ready[g]=1 and beats are dropped until a send_last transfer, then IDLE.
- Loopback (dest==g) is legal.
- Non-granted ports: send_ready=0. Non-addressed ports: recv_valid=0, recv_data=0, recv_last=0.
- rr_ptr<=g on the last transfer of every packet, including CTRL_ID and discarded packets.
- busy=1 in HEADER/STREAM/DISCARD. grant_id=g in those states.
- Timeout (TIMEOUT>0):
  - Counter clears on every transfer and on entering HEADER.
  - Counter increments each cycle in HEADER/STREAM/DISCARD without a transfer.
  - When counter==TIMEOUT: timeout_err pulses, state goes to IDLE, and the remaining beats of that packet are re-arbitrated as a new packet.
- A request that deasserts before its grant lands: HEADER waits, subject to the timeout.
- Simultaneous last transfer and new requests: IDLE is entered first. The next grant is never issued in the same cycle as a last transfer, so there is at least 1 idle cycle between packets.

Test Plan:
- Reset with random inputs held -> all outputs 0. Release; port1 sends header 0x24 (src1, dest2) + 0xAA(last) -> grant_id=1 one cycle later; recv port2 sees 0x24 then 0xAA with recv_last; back to IDLE.
- Ports 0, 1, 2 all requesting 1-beat packets continuously -> grant order 0, 1, 2, 0. Assert port3 (CTRL) mid-stream -> port3 granted next after the current last, ahead of the round-robin candidate.
- recv_ready[dest]=0 for 5 cycles mid-STREAM -> send_ready[g]=0 for those 5 cycles; no beat lost or duplicated; data order preserved.
- NUM_PORTS=3, header dest=3 -> hdr_err pulse; 3 beats consumed with no recv_valid anywhere; IDLE after last. Header src field mismatch -> hdr_err pulse, packet still delivered.
- TIMEOUT=4, granted sender stops after header -> timeout_err pulses on the 4th idle cycle; busy=0 the next cycle.
- rst_n asserted mid-STREAM -> outputs 0 immediately (async); after release, a fresh packet routes normally.
